// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline types and constants for the front-end stages.
// No logic; no latency; no flow control.
// Imported by fetch_stage and pc_reg.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

  // Instruction fetch is word-granular, so redirect targets drop their byte offset.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register with redirect > stall > sequential next-PC selection.
// Latency: 1 cycle from redirect/stall inputs to PCF; PCPlus4F is combinational.
// Backpressure: StallF holds the PC unless a redirect is taken the same cycle.
module pc_reg
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallF,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetA,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCPlus4F
);

  logic [XLEN-1:0] pc_next;

  assign PCPlus4F = PCF + 32'd4;

  always_comb begin
    pc_next = PCPlus4F;
    if (PCSrcE) begin
      pc_next = PCTargetA;
    end else if (StallF) begin
      pc_next = PCF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      PCF <= RESET_PC;
    end else begin
      PCF <= pc_next;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage with IF/ID register; optional stall/flush counters under FETCH_PERF_COUNT_EN.
// Latency: instruction at PCF in cycle n reaches InstrD/PCD in cycle n+1.
// Backpressure: StallF holds PC, StallD holds IF/ID, FlushD inserts a bubble (flush beats stall).
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic [XLEN-1:0] InstrF,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
`ifdef FETCH_PERF_COUNT_EN
  output logic [31:0]     StallCount,
  output logic [31:0]     FlushCount,
`endif
  output logic            MisalignF
);

  logic [XLEN-1:0] pc_plus4_f;
  if_id_t          if_id_q;
  if_id_t          if_id_bubble;
  if_id_t          if_id_fetch;

  assign MisalignF = PCSrcE && (PCTargetE[1:0] != 2'b00);

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .StallF    (StallF),
    .PCSrcE    (PCSrcE),
    .PCTargetA (align_word(PCTargetE)),
    .PCF       (PCF),
    .PCPlus4F  (pc_plus4_f)
  );

  always_comb begin
    if_id_bubble          = '0;
    if_id_bubble.instr    = NOP_INSTR;
    if_id_fetch.instr     = InstrF;
    if_id_fetch.pc        = PCF;
    if_id_fetch.pc_plus4  = pc_plus4_f;
    if_id_fetch.valid     = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || FlushD) begin
      if_id_q <= if_id_bubble;
    end else if (!StallD) begin
      if_id_q <= if_id_fetch;
    end
  end

  assign InstrD   = if_id_q.instr;
  assign PCD      = if_id_q.pc;
  assign PCPlus4D = if_id_q.pc_plus4;
  assign ValidD   = if_id_q.valid;

`ifdef FETCH_PERF_COUNT_EN
  // A redirect overrides the stall, so that cycle is not counted as lost to it.
  always_ff @(posedge clk) begin
    if (rst) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (StallF && !PCSrcE) begin
        StallCount <= StallCount + 32'd1;
      end
      if (FlushD) begin
        FlushCount <= FlushCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage: expected IF/ID state queued per cycle, checked by a monitor.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        StallF = 1'b0;
  logic        StallD = 1'b0;
  logic        FlushD = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'h0;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic        MisalignF;
`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] StallCount;
  logic [31:0] FlushCount;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          due;
    logic [31:0] pcf;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] p4d;
    logic        vld;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign InstrF = imem(PCF);

  fetch_stage #(
    .RESET_PC  (32'h0000_0100),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .InstrF    (InstrF),
    .PCF       (PCF),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD),
`ifdef FETCH_PERF_COUNT_EN
    .StallCount(StallCount),
    .FlushCount(FlushCount),
`endif
    .MisalignF (MisalignF)
  );

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares the DUT state once the edge an expectation was queued for has passed.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      check("PCF", PCF, e.pcf);
      check("InstrD", InstrD, e.instr);
      check("PCD", PCD, e.pcd);
      check("PCPlus4D", PCPlus4D, e.p4d);
      check("ValidD", {31'b0, ValidD}, {31'b0, e.vld});
    end
  end

  // Drive one cycle of inputs and queue the state expected after the next edge.
  task automatic vec(input logic r, input logic sf, input logic sd, input logic fd,
                     input logic ps, input logic [31:0] tgt, input logic mis,
                     input logic [31:0] pcf, input logic [31:0] instr,
                     input logic [31:0] pcd, input logic [31:0] p4d, input logic vld);
    exp_t e;
    rst = r; StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt;
    #1;
    check("MisalignF", {31'b0, MisalignF}, {31'b0, mis});
    e.due = cyc + 1; e.pcf = pcf; e.instr = instr; e.pcd = pcd; e.p4d = p4d; e.vld = vld;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    @(posedge clk);
    #1;
    //   rst sf sd fd ps target        mis  PCF            InstrD                PCD            PCPlus4D       V
    vec(1, 0, 0, 0, 0, 32'h0,         0, 32'h100,       NOP,                  32'h0,         32'h0,         0);
    vec(1, 0, 0, 0, 0, 32'h0,         0, 32'h100,       NOP,                  32'h0,         32'h0,         0);
    vec(0, 0, 0, 0, 0, 32'h0,         0, 32'h104,       imem(32'h100),        32'h100,       32'h104,       1);
    vec(0, 0, 0, 0, 0, 32'h0,         0, 32'h108,       imem(32'h104),        32'h104,       32'h108,       1);
    // Wrap-around fetch near the top of the address space.
    vec(0, 0, 0, 1, 1, 32'hFFFF_FFF8, 0, 32'hFFFF_FFF8, NOP,                  32'h0,         32'h0,         0);
    vec(0, 0, 0, 0, 0, 32'h0,         0, 32'hFFFF_FFFC, imem(32'hFFFF_FFF8),  32'hFFFF_FFF8, 32'hFFFF_FFFC, 1);
    vec(0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         imem(32'hFFFF_FFFC),  32'hFFFF_FFFC, 32'h0,         1);
    vec(0, 0, 0, 0, 0, 32'h403,       0, 32'h4,         imem(32'h0),          32'h0,         32'h4,         1);
    // Stall at PCF=0x20, then a stall with live IF/ID contents.
    vec(0, 0, 0, 1, 1, 32'h20,        0, 32'h20,        NOP,                  32'h0,         32'h0,         0);
    vec(0, 1, 1, 0, 0, 32'h0,         0, 32'h20,        NOP,                  32'h0,         32'h0,         0);
    vec(0, 1, 1, 0, 0, 32'h0,         0, 32'h20,        NOP,                  32'h0,         32'h0,         0);
    vec(0, 0, 0, 0, 0, 32'h0,         0, 32'h24,        imem(32'h20),         32'h20,        32'h24,        1);
    vec(0, 1, 1, 0, 0, 32'h0,         0, 32'h24,        imem(32'h20),         32'h20,        32'h24,        1);
    vec(0, 0, 1, 0, 0, 32'h0,         0, 32'h28,        imem(32'h20),         32'h20,        32'h24,        1);
    vec(0, 1, 0, 0, 0, 32'h0,         0, 32'h28,        imem(32'h28),         32'h28,        32'h2C,        1);
    vec(0, 0, 0, 0, 0, 32'h0,         0, 32'h2C,        imem(32'h28),         32'h28,        32'h2C,        1);
    // Redirect beats StallF; flush squashes the wrong-path fetch.
    vec(0, 1, 0, 1, 1, 32'h400,       0, 32'h400,       NOP,                  32'h0,         32'h0,         0);
    vec(0, 0, 0, 0, 0, 32'h0,         0, 32'h404,       imem(32'h400),        32'h400,       32'h404,       1);
    // Misaligned target is reported and truncated; flush beats StallD.
    vec(0, 0, 1, 1, 1, 32'h403,       1, 32'h400,       NOP,                  32'h0,         32'h0,         0);
    vec(0, 0, 0, 0, 0, 32'h0,         0, 32'h404,       imem(32'h400),        32'h400,       32'h404,       1);
    // Reset overrides redirect, stall and flush.
    vec(1, 1, 1, 1, 1, 32'h800,       0, 32'h100,       NOP,                  32'h0,         32'h0,         0);
    vec(0, 0, 0, 0, 0, 32'h0,         0, 32'h104,       imem(32'h100),        32'h100,       32'h104,       1);
`ifdef FETCH_PERF_COUNT_EN
    vec(1, 0, 0, 0, 0, 32'h0,         0, 32'h100,       NOP,                  32'h0,         32'h0,         0);
    check("StallCount_rst", StallCount, 32'd0);
    check("FlushCount_rst", FlushCount, 32'd0);
    vec(0, 1, 1, 0, 0, 32'h0,         0, 32'h100,       NOP,                  32'h0,         32'h0,         0);
    vec(0, 1, 1, 0, 0, 32'h0,         0, 32'h100,       NOP,                  32'h0,         32'h0,         0);
    vec(0, 1, 1, 0, 0, 32'h0,         0, 32'h100,       NOP,                  32'h0,         32'h0,         0);
    vec(0, 0, 0, 1, 0, 32'h0,         0, 32'h104,       NOP,                  32'h0,         32'h0,         0);
    vec(0, 0, 0, 1, 0, 32'h0,         0, 32'h108,       NOP,                  32'h0,         32'h0,         0);
    vec(0, 1, 0, 0, 1, 32'h200,       0, 32'h200,       imem(32'h108),        32'h108,       32'h10C,       1);
    check("StallCount", StallCount, 32'd3);
    check("FlushCount", FlushCount, 32'd2);
    vec(1, 0, 0, 0, 0, 32'h0,         0, 32'h100,       NOP,                  32'h0,         32'h0,         0);
    check("StallCount_clr", StallCount, 32'd0);
    check("FlushCount_clr", FlushCount, 32'd0);
`endif
    rst = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations unchecked, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Fetch stage plus IF/ID pipeline register, directly upstream of the decode stage and the decode/execute register.
- Owns the program counter and drives the instruction-memory address.
- Selects the next PC from sequential PC+4 or a resolved redirect from execute.
- Captures the fetched instruction, PC and PC+4 into registered decode-stage outputs, with stall and flush (bubble) control.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction word (addi x0,x0,0) injected into InstrD on flush/reset.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- StallF  in  1  hold PCF (hazard unit, load-use).
- StallD  in  1  hold IF/ID register contents.
- FlushD  in  1  replace IF/ID contents with a bubble.
- PCSrcE  in  1  redirect taken (branch taken or jump) resolved in execute.
- PCTargetE  in  32  redirect target from execute.
- InstrF  in  32  instruction word from combinational instruction memory at PCF.
- PCF  out  32  current fetch PC, instruction-memory address.
- InstrD  out  32  instruction presented to decode.
- PCD  out  32  PC of InstrD.
- PCPlus4D  out  32  PCD+4.
- ValidD  out  1  1 = InstrD is a real fetched instruction; 0 = bubble.
- MisalignF  out  1  combinational: PCTargetE[1:0]!=0 while PCSrcE=1.

Behaviour:
- Reset (rst=1 at edge): PCF<=RESET_PC, InstrD<=NOP_INSTR, PCD<=0, PCPlus4D<=0, ValidD<=0. Reset overrides all other inputs, including mid-stall and mid-flush.
- PCPlus4F = PCF+32'd4, modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
- PC next-state priority, per edge when not in reset:
  - 1) PCSrcE=1: PCF<={PCTargetE[31:2],2'b00}. Redirect beats StallF.
  - 2) StallF=1: PCF holds.
  - 3) Otherwise: PCF<=PCPlus4F.
- IF/ID next-state priority:
  - 1) FlushD=1: InstrD<=NOP_INSTR, ValidD<=0, PCD<=0, PCPlus4D<=0. Flush beats StallD.
  - 2) StallD=1: all IF/ID outputs hold.
  - 3) Otherwise: InstrD<=InstrF, PCD<=PCF, PCPlus4D<=PCPlus4F, ValidD<=1.
- Latency: an instruction at PCF in cycle n appears on InstrD/PCD in cycle n+1 unless stalled or flushed.
- Redirect: the instruction fetched in the redirect cycle must be squashed. The hazard unit asserts FlushD with PCSrcE; this block does not self-flush.
- MisalignF: informational only. Low target bits are always forced to 0 in PCF.
- Other outputs have no reset dependency beyond the values listed above. No combinational path from any input to InstrD/PCD/PCPlus4D/ValidD.

Optional Feature:
- Macro: FETCH_PERF_COUNT_EN.
- Defined: adds outputs StallCount[31:0] and FlushCount[31:0].
  - StallCount increments each cycle StallF=1 and PCSrcE=0.
  - FlushCount increments each cycle FlushD=1.
  - Both reset to 0 on rst, wrap modulo 2^32, saturate never.
- Undefined: ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package riscv_pkg: NOP_INSTR constant (32'h0000_0013), XLEN=32, and a typedef if_id_t struct {instr, pc, pc_plus4, valid}.
- The IF/ID register uses if_id_t.
- Sub-module pc_reg (PC register plus next-PC mux with the priority above) is natural. The IF/ID register stays inline.

Test Plan:
- Reset with RESET_PC=32'h100, rst held 2 cycles: PCF=0x100, InstrD=0x00000013, ValidD=0. First cycle after release: PCF=0x104, PCD=0x100, ValidD=1, InstrD=InstrF sampled at 0x100.
- Sequential fetch from 0xFFFF_FFF8, 3 cycles: PCF sequence 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004. PCPlus4D at PCD=0xFFFF_FFFC equals 0x0.
- StallF=StallD=1 for 2 cycles at PCF=0x20: PCF stays 0x20, InstrD/PCD unchanged. Release: PCF=0x24, PCD=0x20.
- PCSrcE=1, PCTargetE=0x400, FlushD=1, StallF=1 same cycle: next PCF=0x400, ValidD=0, InstrD=0x13. Following cycle: PCD=0x400, ValidD=1.
- PCSrcE=1, PCTargetE=0x403: MisalignF=1 that cycle, next PCF=0x400. FlushD=1 with StallD=1 gives a bubble (flush wins).
- FETCH_PERF_COUNT_EN defined, 3 stall cycles + 2 flush cycles + 1 redirect cycle with StallF=1: StallCount=3, FlushCount=2. rst clears both to 0.
